// File: rtl/kamacore_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kamacore_pkg : shared widths, opcodes and sequencer state encoding         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package kamacore_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [6:0] OPCODE_SB_TYPE = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_DECODE  = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_ISSUE   = 2'd3;

  typedef enum logic [1:0] {
    FETCH   = ST_FETCH,
    DECODE  = ST_DECODE,
    RESOLVE = ST_RESOLVE,
    ISSUE   = ST_ISSUE
  } state_e;

endpackage
`default_nettype wire

// File: rtl/kamacore_branching_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kamacore_branching_unit : SB-type branch condition and offset decode       |
// | Revision               : 1.0                                               |
// +----------------------------------------------------------------------------+
module kamacore_branching_unit
  import kamacore_pkg::*;
(
  input  logic [CPU_WIDTH-1:0]  instr,
  input  logic [CPU_WIDTH-1:0]  rs1_data,
  input  logic [CPU_WIDTH-1:0]  rs2_data,
  output logic                  taken,
  output logic [ADDR_WIDTH-1:0] offset
);

  logic [2:0]  funct3;
  logic [12:0] imm;
  logic        unused_fields;

  assign funct3 = instr[14:12];
  assign imm    = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign offset = {{(ADDR_WIDTH-13){imm[12]}}, imm};

  // Register indices and opcode are consumed by the sequencer, not here.
  assign unused_fields = ^{instr[24:15], instr[6:0]};

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken = (rs1_data <  rs2_data);
      F3_BGEU: taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/kamacore_branch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kamacore_branch_sequencer : fetch/decode/resolve/issue control with flush  |
// | Revision                 : 1.0                                             |
// +----------------------------------------------------------------------------+
module kamacore_branch_sequencer
  import kamacore_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_ack,
  input  logic [CPU_WIDTH-1:0]  fetch_data,
  output logic [4:0]            rf_rs1_addr,
  output logic [4:0]            rf_rs2_addr,
  input  logic [CPU_WIDTH-1:0]  rf_rs1_data,
  input  logic [CPU_WIDTH-1:0]  rf_rs2_data,
  output logic                  issue_valid,
  output logic [CPU_WIDTH-1:0]  issue_instr,
  output logic [ADDR_WIDTH-1:0] issue_pc,
  input  logic                  issue_ready,
  output logic                  flush,
  input  logic                  halt
);

  state_e                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CPU_WIDTH-1:0]  ir;
  logic                  started;
  logic                  br_taken;
  logic [ADDR_WIDTH-1:0] br_offset;
  logic [ADDR_WIDTH-1:0] pc_seq;

  kamacore_branching_unit u_branching_unit (
    .instr    (ir),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .taken    (br_taken),
    .offset   (br_offset)
  );

  assign pc_seq = pc + ADDR_WIDTH'(4);

  // started keeps fetch_req low through reset and the release cycle.
  assign fetch_req   = started && (state == FETCH) && !halt;
  assign fetch_addr  = pc;
  assign rf_rs1_addr = (state == DECODE) ? ir[19:15] : 5'd0;
  assign rf_rs2_addr = (state == DECODE) ? ir[24:20] : 5'd0;
  assign issue_valid = (state == ISSUE);
  assign issue_instr = (state == ISSUE) ? ir : '0;
  assign issue_pc    = (state == ISSUE) ? pc : '0;
  assign flush       = (state == RESOLVE) && br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        FETCH: begin
          if (fetch_req && fetch_ack) begin
            ir    <= fetch_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= (ir[6:0] == OPCODE_SB_TYPE) ? RESOLVE : ISSUE;
        end
        RESOLVE: begin
          pc    <= br_taken ? (pc + br_offset) : pc_seq;
          state <= FETCH;
        end
        ISSUE: begin
          if (issue_ready) begin
            pc    <= pc_seq;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kamacore_branch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_kamacore_branch_sequencer : randomized + directed self-checking bench   |
// | Revision                    : 1.0                                          |
// +----------------------------------------------------------------------------+
module tb_kamacore_branch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        fetch_ack = 1'b0;
  logic        issue_ready = 1'b0;
  logic [31:0] fetch_data = '0;
  logic [31:0] rf_rs1_data = '0;
  logic [31:0] rf_rs2_data = '0;
  logic        fetch_req, issue_valid, flush;
  logic [31:0] fetch_addr, issue_instr, issue_pc;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;

  kamacore_branch_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ack   (fetch_ack),
    .fetch_data  (fetch_data),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_pc    (issue_pc),
    .issue_ready (issue_ready),
    .flush       (flush),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read, data one cycle after the address.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    rf_rs1_data <= regs[rf_rs1_addr];
    rf_rs2_data <= regs[rf_rs2_addr];
  end

  // Model: 0 = waiting for a fetch, 1 = decode cycle, 2 = resolve/issue cycle.
  int          m_step = 0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_ir = '0;
  bit          m_started = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic bit is_branch(input logic [31:0] instr);
    return instr[6:0] == 7'b1100011;
  endfunction

  function automatic logic [31:0] br_offset(input logic [31:0] instr);
    int v;
    v = 2 * int'(instr[11:8]) + 32 * int'(instr[30:25]) + 2048 * int'(instr[7]);
    if (instr[31]) v = v - 4096;
    return 32'(v);
  endfunction

  function automatic bit br_taken(input logic [31:0] instr);
    logic [31:0] a, b;
    a = regs[instr[19:15]];
    b = regs[instr[24:20]];
    case (instr[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_alu(input logic [31:0] r);
    return {r[31:7], 7'b0010011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    bit in_decode, in_last, br;
    in_decode = (m_step == 1);
    in_last   = (m_step == 2);
    br        = is_branch(m_ir);
    check("fetch_req",   32'(fetch_req), 32'(rst_n && m_started && m_step == 0 && !halt));
    check("fetch_addr",  fetch_addr, m_pc);
    check("rf_rs1_addr", 32'(rf_rs1_addr), in_decode ? 32'(m_ir[19:15]) : 32'd0);
    check("rf_rs2_addr", 32'(rf_rs2_addr), in_decode ? 32'(m_ir[24:20]) : 32'd0);
    check("issue_valid", 32'(issue_valid), 32'(in_last && !br));
    check("issue_instr", issue_instr, (in_last && !br) ? m_ir : 32'd0);
    check("issue_pc",    issue_pc,    (in_last && !br) ? m_pc : 32'd0);
    check("flush",       32'(flush),  32'(in_last && br && br_taken(m_ir)));
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, then
  // advance the model by the rising edge that follows.
  task automatic do_cycle(input bit rn, input bit h, input bit a,
                          input logic [31:0] d, input bit r);
    @(negedge clk);
    rst_n = rn; halt = h; fetch_ack = a; fetch_data = d; issue_ready = r;
    if (!rn) begin
      m_step = 0; m_pc = RST_PC; m_ir = '0; m_started = 1'b0;
    end
    #1;
    compare_outputs();
    if (rn) begin
      case (m_step)
        0: if (m_started && !h && a) begin m_ir = d; m_step = 1; end
        1: m_step = 2;
        default: begin
          if (is_branch(m_ir)) begin
            m_pc = br_taken(m_ir) ? m_pc + br_offset(m_ir) : m_pc + 32'd4;
            m_step = 0;
          end else if (r) begin
            m_pc = m_pc + 32'd4;
            m_step = 0;
          end
        end
      endcase
      m_started = 1'b1;
    end
  endtask

  task automatic cyc(input bit h, input bit a, input logic [31:0] d, input bit r);
    do_cycle(1'b1, h, a, d, r);
  endtask

  // Fetch one instruction immediately, hold issue_ready low for ready_low
  // issue cycles, and count flush / issue_valid cycles seen along the way.
  task automatic exec(input logic [31:0] instr, input int ready_low,
                      output int fc, output int ivc);
    int k;
    fc = 0; ivc = 0;
    cyc(1'b0, 1'b1, instr, 1'b0);
    check("exec_fetch_taken", 32'(m_step), 32'd1);
    k = 0;
    while (m_step != 0 && k < 40) begin
      cyc(1'b0, 1'b1, $urandom, k > ready_low);
      if (flush) fc++;
      if (issue_valid) ivc++;
      k++;
    end
    check("exec_timeout", 32'(m_step), 32'd0);
  endtask

  int fc, ivc;
  logic [31:0] hold_instr, hold_pc, rnd;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[1] = 32'd5; regs[2] = 32'd5; regs[3] = 32'hFFFF_FFFF; regs[4] = 32'd1;
    regs[5] = 32'h8000_0000; regs[6] = 32'h7FFF_FFFF; regs[7] = 32'd5;

    // Reset state
    repeat (3) do_cycle(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
    check("rst_fetch_addr", fetch_addr, 32'h10);
    check("rst_fetch_req", 32'(fetch_req), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    cyc(1'b0, 1'b1, $urandom, 1'b0);
    check("release_fetch_req", 32'(fetch_req), 32'd0);

    // BEQ taken at 0x10, offset 8
    exec(enc_br(3'd0, 5'd1, 5'd2, 13'd8), 0, fc, ivc);
    check("beq_flush_cycles", 32'(fc), 32'd1);
    check("beq_issue_valid", 32'(ivc), 32'd0);
    check("beq_model_pc", m_pc, 32'h18);
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("beq_fetch_addr", fetch_addr, 32'h18);

    // Back to 0x10, then BNE not taken
    exec(enc_br(3'd0, 5'd1, 5'd2, -13'sd8), 0, fc, ivc);
    exec(enc_br(3'd1, 5'd1, 5'd2, 13'd64), 0, fc, ivc);
    check("bne_flush_cycles", 32'(fc), 32'd0);
    check("bne_model_pc", m_pc, 32'h14);

    // BLTU 0xFFFFFFFF < 1 false; BLT -1 < 1 true
    exec(enc_br(3'd6, 5'd3, 5'd4, 13'd100), 0, fc, ivc);
    check("bltu_flush_cycles", 32'(fc), 32'd0);
    check("bltu_model_pc", m_pc, 32'h18);
    exec(enc_br(3'd4, 5'd3, 5'd4, 13'd8), 0, fc, ivc);
    check("blt_flush_cycles", 32'(fc), 32'd1);
    check("blt_model_pc", m_pc, 32'h20);

    // Non-branch at 0x20 with issue_ready low for 3 cycles
    rnd = enc_alu($urandom);
    cyc(1'b0, 1'b1, rnd, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, $urandom, 1'b0);
    hold_instr = issue_instr; hold_pc = issue_pc;
    cyc(1'b0, 1'b1, $urandom, 1'b0);
    cyc(1'b0, 1'b1, $urandom, 1'b0);
    check("stall_instr_stable", issue_instr, hold_instr);
    check("stall_instr_value", issue_instr, rnd);
    check("stall_pc_stable", issue_pc, 32'h20);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("after_issue_fetch_addr", fetch_addr, 32'h24);
    check("stall_pc_hold", hold_pc, 32'h20);

    // Wrap: jump to 0xFFFFFFFC, then a non-branch
    exec(enc_br(3'd0, 5'd1, 5'd2, -13'sd40), 0, fc, ivc);
    check("jump_model_pc", m_pc, 32'hFFFF_FFFC);
    exec(enc_alu($urandom), 0, fc, ivc);
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("wrap_fetch_addr", fetch_addr, 32'h0);

    // halt blocks fetch
    repeat (3) cyc(1'b1, 1'b1, $urandom, 1'b1);
    check("halt_fetch_req", 32'(fetch_req), 32'd0);
    check("halt_no_latch", 32'(m_step), 32'd0);

    // Reset during RESOLVE of a taken branch
    cyc(1'b0, 1'b1, enc_br(3'd0, 5'd1, 5'd2, 13'd16), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("midrst_flush", 32'(flush), 32'd0);
    check("midrst_pc", fetch_addr, 32'h10);
    do_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("midrst_restart_req", 32'(fetch_req), 32'd1);
    check("midrst_restart_addr", fetch_addr, 32'h10);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(1, 0) == 1)
        rnd = enc_br(3'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                     5'($urandom_range(7, 0)), 13'($urandom_range(255, 0) * 2 - 256));
      else
        rnd = enc_alu($urandom);
      if (i == 300) begin
        do_cycle(1'b0, 1'b0, 1'b1, rnd, 1'b1);
      end else begin
        cyc($urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1, rnd,
            $urandom_range(1, 0) == 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
